// File: rtl/wb_commit_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_commit_queue
// Description : Writeback commit queue sitting in front of the register-file
//               write port. Accepts completed instructions from MEM, resolves
//               the destination register and write data when the instruction
//               is accepted (ALU, MEM, LINK R7<-PC+2, LBI Rs<-imm), buffers up
//               to DEPTH results and retires one per cycle into a registered
//               write port. Publishes a pending-destination mask for decode
//               hazard checks and a sticky halted flag.
//
// Ports       : clk        rising-edge clock
//               rst        asynchronous active-low reset
//               in_valid   MEM result valid
//               in_ready   queue can accept (not full, not halted)
//               in_wen     instruction writes a register
//               in_sel     00 ALU, 01 MEM, 10 LINK, 11 LBI
//               in_dst     destination for ALU/MEM
//               in_rs      destination for LBI
//               in_alu     ALU result
//               in_mem     memory read data
//               in_imm     sign-extended immediate
//               in_pc      PC of the instruction
//               in_halt    instruction is HALT
//               wb_hold    write port unavailable, no retire this cycle
//               wr_en      register write enable
//               wr_addr    register write address
//               wr_data    register write data
//               busy_mask  bit r set: a queued writing entry targets Rr
//               halted     sticky, a HALT entry has retired
//
// Build option: WB_BYPASS_EN - when defined, an input accepted into an empty
//               queue with wb_hold low is written combinationally in the
//               same cycle and never stored.
//
// Revision    : 1.0 - initial release
// ============================================================================
module wb_commit_queue #(
  parameter int DEPTH = 2,
  parameter int DW    = 16,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_wen,
  input  logic [1:0]           in_sel,
  input  logic [AW-1:0]        in_dst,
  input  logic [AW-1:0]        in_rs,
  input  logic [DW-1:0]        in_alu,
  input  logic [DW-1:0]        in_mem,
  input  logic [DW-1:0]        in_imm,
  input  logic [DW-1:0]        in_pc,
  input  logic                 in_halt,
  input  logic                 wb_hold,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_data,
  output logic [2**AW-1:0]     busy_mask,
  output logic                 halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0]    SEL_ALU    = 2'b00;
  localparam logic [1:0]    SEL_MEM    = 2'b01;
  localparam logic [1:0]    SEL_LINK   = 2'b10;
  localparam logic [1:0]    SEL_LBI    = 2'b11;
  localparam logic [AW-1:0] LINK_REG   = AW'(7);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Queue storage
  logic [DEPTH-1:0] ent_wen_q, ent_wen_d;
  logic [DEPTH-1:0] ent_halt_q, ent_halt_d;
  logic [AW-1:0]    ent_addr_q [DEPTH];
  logic [AW-1:0]    ent_addr_d [DEPTH];
  logic [DW-1:0]    ent_data_q [DEPTH];
  logic [DW-1:0]    ent_data_d [DEPTH];

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic             halted_q, halted_d;

  // Resolved view of the incoming instruction
  logic             res_wen;
  logic [AW-1:0]    res_addr;
  logic [DW-1:0]    res_data;

  logic             accept;
  logic             retire;
  logic             bypass;
  logic             push;
  logic             halt_retire;
  logic [DEPTH-1:0] slot_valid;

  // HALT never writes a register, whatever its wen bit says.
  assign res_wen = in_wen & ~in_halt;

  always_comb begin
    res_addr = in_dst;
    res_data = in_alu;
    case (in_sel)
      SEL_ALU:  begin res_addr = in_dst;   res_data = in_alu;          end
      SEL_MEM:  begin res_addr = in_dst;   res_data = in_mem;          end
      SEL_LINK: begin res_addr = LINK_REG; res_data = in_pc + DW'(2);  end
      SEL_LBI:  begin res_addr = in_rs;    res_data = in_imm;          end
    endcase
  end

  assign in_ready    = (count_q != FULL_COUNT) & ~halted_q;
  assign accept      = in_valid & in_ready;
  assign retire      = (count_q != '0) & ~wb_hold;
  assign halt_retire = retire & ent_halt_q[rd_ptr_q];

`ifdef WB_BYPASS_EN
  assign bypass  = accept & (count_q == '0) & ~wb_hold;
  assign wr_en   = bypass ? res_wen  : wr_en_q;
  assign wr_addr = bypass ? res_addr : wr_addr_q;
  assign wr_data = bypass ? res_data : wr_data_q;
`else
  assign bypass  = 1'b0;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
`endif

  // An entry accepted in the same cycle a HALT retires sits behind the HALT
  // and is dropped along with everything else still queued.
  assign push   = accept & ~bypass & ~halt_retire;
  assign halted = halted_q;

  always_comb begin
    ent_wen_d  = ent_wen_q;
    ent_halt_d = ent_halt_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + CW'(push) - CW'(retire);
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    halted_d   = halted_q;

    if (retire) begin
      wr_en_d   = ent_wen_q[rd_ptr_q];
      wr_addr_d = ent_addr_q[rd_ptr_q];
      wr_data_d = ent_data_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + PW'(1);
    end

    // Keep the registered copy in step so the port holds the bypassed
    // address/data once the combinational path goes away.
    if (bypass) begin
      wr_addr_d = res_addr;
      wr_data_d = res_data;
      if (in_halt) halted_d = 1'b1;
    end

    if (push) begin
      ent_wen_d[wr_ptr_q]  = res_wen;
      ent_halt_d[wr_ptr_q] = in_halt;
      ent_addr_d[wr_ptr_q] = res_addr;
      ent_data_d[wr_ptr_q] = res_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end

    if (halt_retire) begin
      halted_d = 1'b1;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_wen_q  <= '0;
      ent_halt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
      end
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      ent_wen_q  <= ent_wen_d;
      ent_halt_q <= ent_halt_d;
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      halted_q   <= halted_d;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PW-1:0] off;
    assign off           = PW'(i) - rd_ptr_q;
    assign slot_valid[i] = ({1'b0, off} < count_q);
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && ent_wen_q[i]) busy_mask[ent_addr_q[i]] = 1'b1;
    end
  end

endmodule
`default_nettype wire
